// File: rtl/cordic_lut_sequencer.sv
// rtl/cordic_lut_sequencer.sv - streams arctan(2^-i) ROM words to the CORDIC Z-datapath
// Optional abort input enabled by defining LUT_SEQ_ABORT_EN.
module cordic_lut_sequencer #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beg_seq,
  input  logic [AW-1:0] iter_last,
`ifdef LUT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          rom_enable,
  output logic [AW-1:0] rom_address,
  input  logic [W-1:0]  rom_data,
  output logic [W-1:0]  angle_out,
  output logic          angle_valid,
  input  logic          angle_ready,
  output logic [AW-1:0] angle_idx,
  output logic          angle_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRESENT, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic          rom_enable_d;
  logic [AW-1:0] rom_address_d;
  logic [W-1:0]  angle_out_d;
  logic          angle_valid_d;
  logic [AW-1:0] angle_idx_d;
  logic          angle_last_d;
  logic          busy_d;
  logic          done_d;

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    last_d        = last_q;
    rom_enable_d  = 1'b0;
    rom_address_d = rom_address;
    angle_out_d   = angle_out;
    angle_valid_d = angle_valid;
    angle_idx_d   = angle_idx;
    angle_last_d  = angle_last;
    done_d        = 1'b0;

    case (state)
      IDLE: begin
        if (beg_seq) begin
          last_d        = iter_last;
          idx_d         = '0;
          rom_enable_d  = 1'b1;
          rom_address_d = '0;
          state_d       = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // The ROM word is only meaningful here; elsewhere it reads back as zero.
        angle_out_d   = rom_data;
        angle_idx_d   = idx;
        angle_last_d  = (idx == last_q);
        angle_valid_d = 1'b1;
        state_d       = PRESENT;
      end
      PRESENT: begin
        if (angle_ready) begin
          angle_valid_d = 1'b0;
          if (angle_last) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d         = idx + 1'b1;
            rom_enable_d  = 1'b1;
            rom_address_d = idx + 1'b1;
            state_d       = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef LUT_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      state_d       = IDLE;
      angle_valid_d = 1'b0;
      rom_enable_d  = 1'b0;
      done_d        = 1'b0;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      last_q      <= '0;
      rom_enable  <= 1'b0;
      rom_address <= '0;
      angle_out   <= '0;
      angle_valid <= 1'b0;
      angle_idx   <= '0;
      angle_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      last_q      <= last_d;
      rom_enable  <= rom_enable_d;
      rom_address <= rom_address_d;
      angle_out   <= angle_out_d;
      angle_valid <= angle_valid_d;
      angle_idx   <= angle_idx_d;
      angle_last  <= angle_last_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_cordic_lut_sequencer.sv
// tb/tb_cordic_lut_sequencer.sv - scoreboard bench for cordic_lut_sequencer
// Exercises the abort path when LUT_SEQ_ABORT_EN is defined.
module tb_cordic_lut_sequencer;
  localparam int W  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          beg_seq;
  logic [AW-1:0] iter_last;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [W-1:0]  rom_data;
  logic [W-1:0]  angle_out;
  logic          angle_valid;
  logic          angle_ready;
  logic [AW-1:0] angle_idx;
  logic          angle_last;
  logic          busy;
  logic          done;
`ifdef LUT_SEQ_ABORT_EN
  logic          abort;
`endif

  always #5 clk = ~clk;

  cordic_lut_sequencer #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .beg_seq(beg_seq), .iter_last(iter_last),
`ifdef LUT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data),
    .angle_out(angle_out), .angle_valid(angle_valid), .angle_ready(angle_ready),
    .angle_idx(angle_idx), .angle_last(angle_last), .busy(busy), .done(done)
  );

  // ROM model: registered read, zero whenever not enabled.
  logic [W-1:0] rom [32];
  always @(posedge clk) rom_data <= rom_enable ? rom[rom_address] : '0;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int start_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit abort_now();
`ifdef LUT_SEQ_ABORT_EN
    return abort;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compares accepted words, first-valid timing, hold stability and done.
  bit           prev_hold = 0;
  bit           prev_valid = 0;
  logic [W-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic         prev_last;
  int           done_due = -1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold  = 0;
      prev_valid = 0;
      done_due   = -1;
    end else begin
      if (done || done_due == edge_cnt) begin
        check("done_pulse", {63'd0, done}, {63'd0, done_due == edge_cnt});
        done_due = -1;
      end
      if (prev_hold && angle_valid) begin
        check("hold_data", angle_out, prev_data);
        check("hold_idx", {59'd0, angle_idx}, {59'd0, prev_idx});
        check("hold_last", {63'd0, angle_last}, {63'd0, prev_last});
      end
      if (angle_valid && !prev_valid && q.size() > 0 && q[0].cyc >= 0)
        check("valid_cycle", 64'(edge_cnt - start_cnt), 64'(q[0].cyc));
      if (angle_valid && angle_ready && !abort_now()) begin
        if (q.size() == 0) begin
          check("unexpected_word_idx", {59'd0, angle_idx}, 64'hffff_ffff_ffff_ffff);
        end else begin
          e = q.pop_front();
          check("word_data", angle_out, e.data);
          check("word_idx", {59'd0, angle_idx}, 64'(e.idx));
          check("word_last", {63'd0, angle_last}, {63'd0, e.last});
          if (angle_last) done_due = edge_cnt + 1;
        end
      end
      prev_hold  = angle_valid && !(angle_ready && !abort_now());
      prev_valid = angle_valid;
      prev_data  = angle_out;
      prev_idx   = angle_idx;
      prev_last  = angle_last;
    end
  end

  task automatic start_seq(input int last, input bit timed);
    @(posedge clk); #1;
    iter_last = AW'(last);
    beg_seq   = 1'b1;
    start_cnt = edge_cnt;
    for (int i = 0; i <= last; i++) begin
      exp_t e;
      e.data = rom[i];
      e.idx  = i;
      e.last = (i == last);
      e.cyc  = timed ? 3 + 3 * i : -1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    beg_seq = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit random_ready);
    int n = 0;
    while (n < 3000 && (busy || q.size() != 0)) begin
      @(posedge clk); #1;
      if (random_ready) angle_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check(name, {63'd0, (q.size() == 0) && !busy}, 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (n < 200 && !angle_valid) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'd0, angle_valid}, 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_enable"}, {63'd0, rom_enable}, 64'd0);
    check({tag, "_rom_address"}, {59'd0, rom_address}, 64'd0);
    check({tag, "_angle_out"}, angle_out, 64'd0);
    check({tag, "_angle_valid"}, {63'd0, angle_valid}, 64'd0);
    check({tag, "_angle_idx"}, {59'd0, angle_idx}, 64'd0);
    check({tag, "_angle_last"}, {63'd0, angle_last}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    real p;
    rom[0]  = 64'h3fe921fb54442d18;
    rom[1]  = 64'h3fddac670561bb4f;
    rom[2]  = 64'h3fcf5b75f92c80dd;
    p = 0.125;
    for (int i = 3; i < 31; i++) begin
      rom[i] = $realtobits($atan(p));
      p = p / 2.0;
    end
    rom[31] = 64'h3e00000000000000;

    rst = 1'b1; beg_seq = 1'b0; iter_last = '0; angle_ready = 1'b0;
`ifdef LUT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, then three back-to-back words with fixed timing.
    angle_ready = 1'b1;
    start_seq(0, 1);
    wait_idle("t1_drain", 0);
    start_seq(2, 1);
    wait_idle("t2_drain", 0);

    // Full table with a randomly stalling consumer.
    start_seq(31, 0);
    wait_idle("t3_drain", 1);
    check("t3_last_word", angle_out, 64'h3e00000000000000);
    angle_ready = 1'b1;

    // beg_seq while presenting, with a different iter_last, must be ignored.
    angle_ready = 1'b0;
    start_seq(3, 0);
    wait_valid("t4_wait_valid");
    iter_last = 5'd5;
    beg_seq = 1'b1;
    @(posedge clk); #1;
    beg_seq = 1'b0;
    angle_ready = 1'b1;
    wait_idle("t4_drain", 0);

    // beg_seq during the DONE cycle is ignored.
    start_seq(1, 0);
    begin
      int n = 0;
      while (n < 100 && !done) begin
        @(posedge clk); #1;
        n++;
      end
      check("t4b_saw_done", {63'd0, done}, 64'd1);
    end
    beg_seq = 1'b1;
    @(posedge clk); #1;
    beg_seq = 1'b0;
    check("t4b_beg_in_done_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1 check("t4b_still_idle", {63'd0, busy}, 64'd0);

    // Asynchronous reset while presenting, then a clean restart from index 0.
    angle_ready = 1'b0;
    start_seq(4, 0);
    wait_valid("t5_wait_valid");
    #2 rst = 1'b1;
    #1 check_zero("t5_async");
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    angle_ready = 1'b1;
    start_seq(1, 1);
    wait_idle("t5_restart_drain", 0);

`ifdef LUT_SEQ_ABORT_EN
    // abort beats angle_ready at index 4.
    angle_ready = 1'b1;
    start_seq(31, 0);
    begin
      int n = 0;
      while (n < 200 && !(angle_valid && angle_idx == 5'd4)) begin
        @(posedge clk); #1;
        n++;
      end
      check("t6_reach_idx4", {63'd0, angle_valid && angle_idx == 5'd4}, 64'd1);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_valid", {63'd0, angle_valid}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    check("t6_rom_enable", {63'd0, rom_enable}, 64'd0);
    q.delete();
    repeat (4) @(posedge clk);
    #1 check("t6_stays_idle", {63'd0, busy}, 64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
